// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready handshake, illegal-opcode pulse and retired-instruction count.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 memReady,
  output logic                 pcWrite,
  output logic                 branch,
  output logic                 iorD,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 memToReg,
  output logic                 regDst,
  output logic                 regWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSrc,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instrCount
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXECUTE = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12
  } stateT;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } ctlT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  stateT          curState;
  stateT          nextState;
  ctlT            ctlQ;
  logic           legalOp;
  logic           fetchDone;
  logic           retire;

  // Moore control word for a state; FETCH's irWrite/pcWrite are added outside.
  function automatic ctlT decodeCtl(input stateT s);
    ctlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = 2'b01;
      end
      DECODE:  c.aluSrcB = 2'b11;
      MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      MEMRD: begin
        c.iorD    = 1'b1;
        c.memRead = 1'b1;
      end
      MEMWB: begin
        c.memToReg = 1'b1;
        c.regWrite = 1'b1;
      end
      MEMWR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECUTE: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b10;
      end
      ALUWB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'b01;
        c.pcSrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
      end
      ADDIWB:  c.regWrite = 1'b1;
      JUMP: begin
        c.pcSrc   = 2'b10;
        c.pcWrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    legalOp = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
              (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
  end

  always_comb begin
    nextState = IDLE;
    case (curState)
      IDLE:    nextState = FETCH;
      FETCH:   nextState = memReady ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      nextState = EXECUTE;
          OP_LW, OP_SW:  nextState = MEMADR;
          OP_BEQ:        nextState = BRANCH;
          OP_ADDI:       nextState = ADDIEX;
          OP_J:          nextState = JUMP;
          default:       nextState = FETCH;
        endcase
      end
      MEMADR:  nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nextState = memReady ? MEMWB : MEMRD;
      MEMWB:   nextState = FETCH;
      MEMWR:   nextState = memReady ? FETCH : MEMWR;
      EXECUTE: nextState = ALUWB;
      ALUWB:   nextState = FETCH;
      BRANCH:  nextState = FETCH;
      ADDIEX:  nextState = ADDIWB;
      ADDIWB:  nextState = FETCH;
      JUMP:    nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (curState)
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: retire = 1'b1;
      MEMWR:                              retire = memReady;
      default:                            retire = 1'b0;
    endcase
  end

  // Control word is registered from the next state so it lines up with curState.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState   <= IDLE;
      ctlQ       <= '0;
      instrCount <= '0;
    end else begin
      curState <= nextState;
      ctlQ     <= decodeCtl(nextState);
      if (retire) instrCount <= instrCount + CNT_WIDTH'(1);
    end
  end

  assign fetchDone = (curState == FETCH) && memReady;

  assign pcWrite  = ctlQ.pcWrite | fetchDone;
  assign irWrite  = fetchDone;
  assign branch   = ctlQ.branch;
  assign iorD     = ctlQ.iorD;
  assign memRead  = ctlQ.memRead;
  assign memWrite = ctlQ.memWrite;
  assign memToReg = ctlQ.memToReg;
  assign regDst   = ctlQ.regDst;
  assign regWrite = ctlQ.regWrite;
  assign ALUSrcA  = ctlQ.aluSrcA;
  assign ALUSrcB  = ctlQ.aluSrcB;
  assign ALUOp    = ctlQ.aluOp;
  assign PCSrc    = ctlQ.pcSrc;
  assign illegal  = (curState == DECODE) && !legalOp;
  assign state    = curState;

endmodule
